// File: rtl/npc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_mem_pkg
// Description : Shared types and defaults for the NPC memory front end.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } mst_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester grant (IFU/LSU) with last-grant memory.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import npc_mem_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req_ifu,
    input  logic req_lsu,
    input  logic accept,
    output logic gnt_valid,
    output logic gnt_lsu
);

    mst_e last_grant_q;
    mst_e last_grant_d;

    always_comb begin
        gnt_valid    = req_ifu | req_lsu;
        gnt_lsu      = req_lsu;
        last_grant_d = last_grant_q;
        // On conflict, round-robin favours whoever did not win last time.
        if (req_ifu && req_lsu) begin
            gnt_lsu = (RR_EN != 0) ? (last_grant_q == MST_IFU) : 1'b1;
        end
        if (accept) begin
            last_grant_d = gnt_lsu ? MST_LSU : MST_IFU;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= MST_IFU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one SRAM bridge port between IFU (read) and LSU (r/w).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RR_EN  = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_wen,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,
    output logic                sram_read,
    output logic [ADDR_W-1:0]   sram_r_addr,
    input  logic [DATA_W-1:0]   sram_r_data,
    output logic                sram_write,
    output logic [ADDR_W-1:0]   sram_w_addr,
    output logic [DATA_W-1:0]   sram_w_data,
    output logic [DATA_W/8-1:0] sram_w_strb
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    mst_e                mst_q, mst_d;
    logic                wen_q, wen_d;
    logic                first_q, first_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                gnt_valid;
    logic                gnt_lsu;
    logic                req_hs;
    logic                resp_hs;
    logic [DATA_W-1:0]   resp_data;

    rr_arbiter2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_ifu   (ifu_req_valid),
        .req_lsu   (lsu_req_valid),
        .accept    (req_hs),
        .gnt_valid (gnt_valid),
        .gnt_lsu   (gnt_lsu)
    );

    // Bridge data arrives in the first RESP cycle; after that the captured copy is used.
    assign resp_data = first_q ? (wen_q ? '0 : sram_r_data) : rdata_q;
    assign resp_hs   = (mst_q == MST_IFU) ? ifu_resp_ready : lsu_resp_ready;

    always_comb begin
        state_d       = state_q;
        mst_d         = mst_q;
        wen_d         = wen_q;
        first_d       = first_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rdata_d       = rdata_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        req_hs        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ifu_req_ready = gnt_valid & ~gnt_lsu;
                lsu_req_ready = gnt_valid & gnt_lsu;
                if (gnt_valid) begin
                    req_hs  = 1'b1;
                    mst_d   = gnt_lsu ? MST_LSU : MST_IFU;
                    wen_d   = gnt_lsu & lsu_req_wen;
                    addr_d  = gnt_lsu ? lsu_req_addr : ifu_req_addr;
                    wdata_d = gnt_lsu ? lsu_req_wdata : '0;
                    wstrb_d = gnt_lsu ? lsu_req_wstrb : '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                first_d = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                first_d = 1'b0;
                if (first_q) begin
                    rdata_d = resp_data;
                end
                if (resp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mst_q   <= MST_IFU;
            wen_q   <= 1'b0;
            first_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            mst_q   <= mst_d;
            wen_q   <= wen_d;
            first_q <= first_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_read      = (state_q == ST_ACCESS) & ~wen_q;
    assign sram_write     = (state_q == ST_ACCESS) & wen_q;
    assign sram_r_addr    = addr_q;
    assign sram_w_addr    = addr_q;
    assign sram_w_data    = wdata_q;
    assign sram_w_strb    = wstrb_q;
    assign ifu_resp_valid = (state_q == ST_RESP) & (mst_q == MST_IFU);
    assign lsu_resp_valid = (state_q == ST_RESP) & (mst_q == MST_LSU);
    assign ifu_resp_data  = ifu_resp_valid ? resp_data : '0;
    assign lsu_resp_data  = lsu_resp_valid ? resp_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed and random bench for sram_arbiter, transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_req_wen, lsu_resp_ready;
    logic [31:0] ifu_req_addr, lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;

    logic        ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid;
    logic [31:0] ifu_resp_data, lsu_resp_data;
    logic        sram_read, sram_write;
    logic [31:0] sram_r_addr, sram_r_data, sram_w_addr, sram_w_data;
    logic [3:0]  sram_w_strb;

    logic        fp_ifu_req_ready, fp_ifu_resp_valid, fp_lsu_req_ready, fp_lsu_resp_valid;
    logic [31:0] fp_ifu_resp_data, fp_lsu_resp_data;
    logic        fp_sram_read, fp_sram_write;
    logic [31:0] fp_sram_r_addr, fp_sram_r_data, fp_sram_w_addr, fp_sram_w_data;
    logic [3:0]  fp_sram_w_strb;

    int n_vec = 0;
    int n_err = 0;
    int fp_lsu_hs = 0;

    always #5 clock = ~clock;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(lsu_resp_data),
        .sram_read(sram_read), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
        .sram_write(sram_write), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data),
        .sram_w_strb(sram_w_strb)
    );

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) u_dut_fp (
        .clock(clock), .reset_n(reset_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(fp_ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(fp_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(fp_ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(fp_lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_resp_valid(fp_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_data(fp_lsu_resp_data),
        .sram_read(fp_sram_read), .sram_r_addr(fp_sram_r_addr), .sram_r_data(fp_sram_r_data),
        .sram_write(fp_sram_write), .sram_w_addr(fp_sram_w_addr), .sram_w_data(fp_sram_w_data),
        .sram_w_strb(fp_sram_w_strb)
    );

    // Bridge stand-in: known data the cycle after a read strobe, noise otherwise.
    function automatic logic [31:0] bridge_val(input logic [31:0] a);
        return a ^ 32'h8000_0413;
    endfunction

    always @(posedge clock) begin
        sram_r_data    <= sram_read ? bridge_val(sram_r_addr) : 32'($urandom);
        fp_sram_r_data <= fp_sram_read ? bridge_val(fp_sram_r_addr) : 32'($urandom);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: idle, or holding one accepted transaction of a given age.
    bit          m_busy, n_busy;
    int          m_age, n_age;
    bit          m_lsu, n_lsu, m_wen, n_wen, m_last_lsu, n_last_lsu;
    logic [31:0] m_addr, n_addr, m_wdata, n_wdata;
    logic [3:0]  m_wstrb, n_wstrb;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_age <= 0; m_lsu <= 0; m_wen <= 0; m_last_lsu <= 0;
            m_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
        end else begin
            m_busy <= n_busy; m_age <= n_age; m_lsu <= n_lsu; m_wen <= n_wen;
            m_last_lsu <= n_last_lsu; m_addr <= n_addr; m_wdata <= n_wdata; m_wstrb <= n_wstrb;
        end
    end

    always @(negedge clock) begin
        bit gi, gl;
        n_busy = m_busy; n_age = m_age; n_lsu = m_lsu; n_wen = m_wen;
        n_last_lsu = m_last_lsu; n_addr = m_addr; n_wdata = m_wdata; n_wstrb = m_wstrb;
        if (!reset_n) begin
            chk("rst_strobes", {sram_read, sram_write}, 0);
            chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
            chk("rst_resp", {ifu_resp_valid, lsu_resp_valid, ifu_resp_data, lsu_resp_data}, 0);
            chk("rst_addr", {sram_r_addr, sram_w_addr}, 0);
            chk("rst_wdata", {sram_w_data, 28'h0, sram_w_strb}, 0);
            n_busy = 0; n_last_lsu = 0;
        end else begin
            chk("fp_ifu_beats_lsu", fp_ifu_req_ready & lsu_req_valid, 0);
            chk("fp_dual_resp", fp_ifu_resp_valid & fp_lsu_resp_valid, 0);
            if (fp_lsu_req_ready) fp_lsu_hs++;
            if (!m_busy) begin
                gi = ifu_req_valid && !(lsu_req_valid && !m_last_lsu);
                gl = lsu_req_valid && !gi;
                chk("ifu_req_ready", ifu_req_ready, gi);
                chk("lsu_req_ready", lsu_req_ready, gl);
                chk("idle_strobes", {sram_read, sram_write}, 0);
                chk("idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
                if (gi || gl) begin
                    n_busy = 1; n_age = 0; n_lsu = gl; n_last_lsu = gl;
                    n_wen = gl && lsu_req_wen;
                    n_addr = gl ? lsu_req_addr : ifu_req_addr;
                    n_wdata = lsu_req_wdata; n_wstrb = lsu_req_wstrb;
                end
            end else begin
                chk("busy_ready", {ifu_req_ready, lsu_req_ready}, 0);
                if (m_age == 0) begin
                    chk("sram_read", sram_read, !m_wen);
                    chk("sram_write", sram_write, m_wen);
                    chk("access_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
                    if (m_wen) begin
                        chk("sram_w_addr", sram_w_addr, m_addr);
                        chk("sram_w_data", sram_w_data, m_wdata);
                        chk("sram_w_strb", sram_w_strb, m_wstrb);
                    end else begin
                        chk("sram_r_addr", sram_r_addr, m_addr);
                    end
                end else begin
                    chk("resp_strobes", {sram_read, sram_write}, 0);
                    chk("ifu_resp_valid", ifu_resp_valid, !m_lsu);
                    chk("lsu_resp_valid", lsu_resp_valid, m_lsu);
                    chk("resp_data", m_lsu ? lsu_resp_data : ifu_resp_data,
                        m_wen ? 32'h0 : bridge_val(m_addr));
                    if (m_lsu ? lsu_resp_ready : ifu_resp_ready) n_busy = 0;
                end
                n_age = m_age + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic single(input bit lsu, input bit wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_data);
        ifu_req_valid = !lsu; lsu_req_valid = lsu; lsu_req_wen = wen;
        ifu_req_addr = addr; lsu_req_addr = addr; lsu_req_wdata = wdata; lsu_req_wstrb = wstrb;
        @(negedge clock);
        chk("lit_req_ready", lsu ? lsu_req_ready : ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0; lsu_req_valid = 0;
        @(negedge clock);
        chk("lit_strobe", {sram_read, sram_write}, wen ? 2'b01 : 2'b10);
        chk("lit_addr", wen ? sram_w_addr : sram_r_addr, addr);
        if (wen) chk("lit_wdata", {sram_w_data, 28'h0, sram_w_strb}, {wdata, 28'h0, wstrb});
        tick();
        @(negedge clock);
        chk("lit_resp_valid", {ifu_resp_valid, lsu_resp_valid}, lsu ? 2'b01 : 2'b10);
        chk("lit_resp_data", lsu ? lsu_resp_data : ifu_resp_data, exp_data);
        tick();
        @(negedge clock);
        chk("lit_back_idle", {ifu_resp_valid, lsu_resp_valid, sram_read, sram_write}, 0);
    endtask

    task automatic wait_ready(output bit got_lsu, output bit ok);
        ok = 0; got_lsu = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (ifu_req_ready || lsu_req_ready) begin
                got_lsu = lsu_req_ready; ok = 1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit got_lsu, ok;
        int fp_base;
        reset_n = 0;
        ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 1;
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = '0; lsu_req_wdata = '0;
        lsu_req_wstrb = '0; lsu_resp_ready = 1;
        repeat (3) tick();
        reset_n = 1;

        single(0, 0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413);
        tick();
        single(1, 1, 32'h8000_1004, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        tick();
        single(1, 1, 32'h8000_2000, 32'h1234_5678, 4'b0000, 32'h0);
        tick();

        // Backpressure on IFU while LSU keeps requesting.
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010; ifu_resp_ready = 0;
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h0000_0100;
        @(negedge clock);
        chk("bp_ifu_granted", {ifu_req_ready, lsu_req_ready}, 2'b10);
        tick();
        ifu_req_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_hold", {ifu_resp_valid, ifu_resp_data}, {1'b1, 32'h0000_0403});
            chk("bp_no_ready", {lsu_req_ready, sram_read, sram_write}, 0);
            tick();
        end
        ifu_resp_ready = 1;
        @(negedge clock);
        chk("bp_release_no_ready", lsu_req_ready, 0);
        tick();
        @(negedge clock);
        chk("bp_lsu_next", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0;
        repeat (3) tick();

        // Asynchronous reset in the middle of an LSU write.
        lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h0000_0200;
        lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wstrb = 4'hF;
        @(negedge clock);
        chk("rst_lsu_accept", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0;
        #3 reset_n = 0;
        #1 chk("rst_async", {sram_write, sram_read, sram_w_addr, lsu_resp_valid}, 0);
        repeat (2) tick();
        reset_n = 1;

        // Conflict from reset: round-robin alternates starting with LSU.
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
        lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_0080;
        fp_base = fp_lsu_hs;
        for (int k = 0; k < 4; k++) begin
            wait_ready(got_lsu, ok);
            chk("rr_timeout", ok, 1);
            chk("rr_order", got_lsu, (k % 2) == 0);
            tick();
        end
        chk("fp_lsu_wins", fp_lsu_hs - fp_base >= 2, 1);
        ifu_req_valid = 0; lsu_req_valid = 0;
        repeat (4) tick();

        for (int i = 0; i < 500; i++) begin
            ifu_req_valid  = 1'($urandom_range(0, 1));
            lsu_req_valid  = 1'($urandom_range(0, 1));
            lsu_req_wen    = 1'($urandom_range(0, 1));
            ifu_req_addr   = $urandom;
            lsu_req_addr   = $urandom;
            lsu_req_wdata  = $urandom;
            lsu_req_wstrb  = 4'($urandom);
            ifu_resp_ready = ($urandom_range(0, 3) != 0);
            lsu_resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
